// File: rtl/mult32x32_ctrl.sv
// Sequencing FSM for the 32x32 multiplier: steps eight 8x16 partial products into the product register.
// Optional abort input enabled by defining MULT32X32_CTRL_ABORT_EN.
module mult32x32_ctrl #(
    parameter int ORDER = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef MULT32X32_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       done,
    output logic [1:0] a_sel,
    output logic       b_sel,
    output logic [2:0] shift_sel,
    output logic       upd_prod,
    output logic       clr_prod
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic       done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        done_d   = 1'b0;
        busy     = 1'b0;
        upd_prod = 1'b0;
        clr_prod = 1'b0;
        a_sel    = 2'd0;
        b_sel    = 1'b0;
        case (state_q)
            IDLE: begin
                // Clear cycle: the product is zeroed on the accepting edge.
                if (start && !reset) begin
                    upd_prod = 1'b1;
                    clr_prod = 1'b1;
                    state_d  = RUN;
                    k_d      = 3'd0;
                end
            end
            RUN: begin
                busy     = 1'b1;
                upd_prod = 1'b1;
                if (ORDER == 0) begin
                    a_sel = k_q[1:0];
                    b_sel = k_q[2];
                end else begin
                    a_sel = k_q[2:1];
                    b_sel = k_q[0];
                end
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
`ifdef MULT32X32_CTRL_ABORT_EN
                if (abort) begin
                    upd_prod = 1'b0;
                    state_d  = IDLE;
                    k_d      = 3'd0;
                    done_d   = 1'b0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte offset of the partial product: A-byte index plus two bytes per B-word.
    assign shift_sel = {1'b0, a_sel} + {1'b0, b_sel, 1'b0};
    assign done      = done_q;

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Bench for mult32x32_ctrl: both ORDER variants side by side, each feeding a behavioural
// product accumulator; results compared against plain 64-bit multiplication.
module tb_mult32x32_ctrl;

    logic clk, reset, start, abort;
    logic [1:0]       busy, done, b_sel, upd, clr;
    logic [1:0][1:0]  a_sel;
    logic [1:0][2:0]  shift;
    logic [63:0]      prod [2];
    logic [31:0]      opa, opb;
    int vectors = 0;
    int miscompares = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mult32x32_ctrl #(.ORDER(g)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
`ifdef MULT32X32_CTRL_ABORT_EN
            .abort     (abort),
`endif
            .busy      (busy[g]),
            .done      (done[g]),
            .a_sel     (a_sel[g]),
            .b_sel     (b_sel[g]),
            .shift_sel (shift[g]),
            .upd_prod  (upd[g]),
            .clr_prod  (clr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic-unit stand-in: accumulates selected byte x word at the commanded offset.
    function automatic logic [63:0] pp(input int i);
        logic [63:0] ab, bw;
        ab = 64'(opa[8*a_sel[i] +: 8]);
        bw = 64'(opb[16*b_sel[i] +: 16]);
        return (ab * bw) << (8 * shift[i]);
    endfunction

    initial begin
        prod[0] = 64'd0;
        prod[1] = 64'd0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (upd[i]) prod[i] <= clr[i] ? 64'd0 : prod[i] + pp(i);
    end

    task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[order%0d] observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input bit st, input bit dn);
        for (int i = 0; i < 2; i++) begin
            chk({tag, ".busy"}, i, 64'(busy[i]), 64'd0);
            chk({tag, ".upd"}, i, 64'(upd[i]), 64'(st));
            chk({tag, ".clr"}, i, 64'(clr[i]), 64'(st));
            chk({tag, ".a_sel"}, i, 64'(a_sel[i]), 64'd0);
            chk({tag, ".b_sel"}, i, 64'(b_sel[i]), 64'd0);
            chk({tag, ".shift"}, i, 64'(shift[i]), 64'd0);
            chk({tag, ".done"}, i, 64'(done[i]), 64'(dn));
        end
    endtask

    // Step k covers A-byte/B-word pair; order 0 walks bytes fastest, order 1 walks words fastest.
    task automatic chk_step(input string tag, input int k);
        int ea, eb;
        for (int i = 0; i < 2; i++) begin
            ea = (i == 0) ? k % 4 : k / 2;
            eb = (i == 0) ? k / 4 : k % 2;
            chk({tag, ".busy"}, i, 64'(busy[i]), 64'd1);
            chk({tag, ".upd"}, i, 64'(upd[i]), 64'd1);
            chk({tag, ".clr"}, i, 64'(clr[i]), 64'd0);
            chk({tag, ".done"}, i, 64'(done[i]), 64'd0);
            chk({tag, ".a_sel"}, i, 64'(a_sel[i]), 64'(ea));
            chk({tag, ".b_sel"}, i, 64'(b_sel[i]), 64'(eb));
            chk({tag, ".shift"}, i, 64'(shift[i]), 64'(ea + 8 * eb / 4));
        end
    endtask

    task automatic chk_prod(input string tag, input logic [63:0] e);
        for (int i = 0; i < 2; i++) chk(tag, i, prod[i], e);
    endtask

    // Called at a negedge; returns shortly after a later negedge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] smask,
                          input int rst_at, input int abt_at);
        logic [63:0] e;
        e = 64'(a) * 64'(b);
        opa = a;
        opb = b;
        start = 1'b1;
        #1 chk_idle("start", 1'b1, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            start = smask[k];
            if (k == rst_at) begin
                start = 1'b0;
                reset = 1'b1;
                #1 chk_idle("rst_mid", 1'b0, 1'b0);
                @(negedge clk);
                reset = 1'b0;
                #1 chk_idle("rst_rel", 1'b0, 1'b0);
                @(negedge clk);
                #1 chk_idle("rst_nodone", 1'b0, 1'b0);
                return;
            end
`ifdef MULT32X32_CTRL_ABORT_EN
            if (k == abt_at) begin
                abort = 1'b1;
                #1;
                for (int i = 0; i < 2; i++) begin
                    chk("abort.upd", i, 64'(upd[i]), 64'd0);
                    chk("abort.busy", i, 64'(busy[i]), 64'd1);
                end
                @(negedge clk);
                abort = 1'b0;
                #1 chk_idle("abort_idle", 1'b0, 1'b0);
                @(negedge clk);
                #1 chk_idle("abort_nodone", 1'b0, 1'b0);
                return;
            end
`endif
            #1 chk_step("step", k);
            @(negedge clk);
        end
        start = 1'b0;
        #1 chk_idle("done", 1'b0, 1'b1);
        chk_prod("product", e);
        @(negedge clk);
        #1 chk_idle("post", 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] he;
        int ph;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        opa = 32'd0;
        opb = 32'd0;
        #1 reset = 1'b1;
        #1 chk_idle("reset", 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1 chk_idle("idle", 1'b0, 1'b0);
        end

        @(negedge clk);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, -1, -1);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 8'h00, -1, -1);
        for (int n = 0; n < 6; n++) run_op($urandom, $urandom, 8'h00, -1, -1);

        // start while busy at steps 3 and 7: single done, no follow-on operation
        run_op($urandom, $urandom, 8'b1000_1000, -1, -1);
        @(negedge clk);
        #1 chk_idle("ignored", 1'b0, 1'b0);

        // reset mid-run, then a full operation must still be correct
        run_op($urandom, $urandom, 8'h00, 4, -1);
        run_op($urandom, $urandom, 8'h00, -1, -1);

`ifdef MULT32X32_CTRL_ABORT_EN
        run_op($urandom, $urandom, 8'h00, -1, 2);
        run_op($urandom, $urandom, 8'h00, -1, -1);
`endif

        // start held high: clear cycle plus 8 steps, done coinciding with the next clear
        ra = $urandom;
        rb = $urandom;
        opa = ra;
        opb = rb;
        he = 64'(ra) * 64'(rb);
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 27; c++) begin
            ph = c % 9;
            #1;
            if (ph == 0) begin
                chk_idle("held_clr", 1'b1, c > 0);
                if (c > 0) chk_prod("held_product", he);
            end else begin
                chk_step("held_step", ph - 1);
            end
            @(negedge clk);
        end
        start = 1'b0;
        #1 chk_idle("held_end", 1'b0, 1'b1);
        chk_prod("held_product_end", he);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
